// File: rtl/conv_kernel_win.sv
// ----------------------------------------------------------------------------
// conv_kernel_win
//   Assembles a 5x5 convolution window from a stream of 5-tap pixel columns.
//   Columns enter a 5-deep shift register; the window for the pixel in the
//   centre column (col 2) is edge-padded using that pixel's frame-position
//   flags and presented on a registered, ready-throttled output.  After the
//   last pixel of a frame two self-generated flush shifts push the final two
//   windows of the frame out without waiting for further input.
//
//   Parameters
//     PAD_MODE            0: out-of-frame taps read 0
//                         1: out-of-frame taps replicate nearest in-frame tap
//   Ports
//     clk                 clock, rising edge
//     arst_n              asynchronous active-low reset
//     kernel_colD_vld_i   new column present (only while m_tready_i = 1)
//     kernel_colD_pos_i   frame-position flags of the pixel owning the column
//     kernel_colD_data_i  column taps, [0] = row +2 (south) .. [4] = row -2
//     m_tready_i          downstream ready, also the shift enable
//     m_tvalid_o          window valid
//     m_tdata_o           window [col][row], col 0 = west (-2)
//     m_tuser_o           centre pixel is first pixel of frame
//     m_tlast_o           centre pixel is last pixel of its line
// ----------------------------------------------------------------------------
package conv_pkg;
    typedef logic [7:0] pixel_t;

    typedef struct packed {
        logic w2;   // x == 0
        logic w1;   // x == 1
        logic e1;   // x == width-2
        logic e2;   // x == width-1
        logic n2;   // y == 0
        logic n1;   // y == 1
        logic s1;   // y == height-2
        logic s2;   // y == height-1
    } kernel_pos_t;
endpackage

// ----------------------------------------------------------------------------
// conv_kernel_win_rowpad
//   Vertical padding of one window column.  Row index 0 is the south-most tap.
//   Ports: col_i taps in, n2_i/n1_i/s1_i/s2_i row masks of the centre pixel,
//   col_o padded taps out.
// ----------------------------------------------------------------------------
module conv_kernel_win_rowpad #(
    parameter int PAD_MODE = 0
) (
    input  conv_pkg::pixel_t [4:0] col_i,
    input  logic                   n2_i,
    input  logic                   n1_i,
    input  logic                   s1_i,
    input  logic                   s2_i,
    output conv_pkg::pixel_t [4:0] col_o
);
    generate
        if (PAD_MODE == 0) begin : g_zero
            always_comb begin
                col_o = col_i;
                if (s2_i | s1_i) col_o[0] = '0;
                if (s2_i)        col_o[1] = '0;
                if (n2_i)        col_o[3] = '0;
                if (n2_i | n1_i) col_o[4] = '0;
            end
        end else begin : g_rep
            always_comb begin
                col_o = col_i;
                if (s2_i) begin
                    col_o[0] = col_i[2];
                    col_o[1] = col_i[2];
                end else if (s1_i) begin
                    col_o[0] = col_i[1];
                end
                if (n2_i) begin
                    col_o[3] = col_i[2];
                    col_o[4] = col_i[2];
                end else if (n1_i) begin
                    col_o[4] = col_i[3];
                end
            end
        end
    endgenerate
endmodule

module conv_kernel_win #(
    parameter int PAD_MODE = 0
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        kernel_colD_vld_i,
    input  conv_pkg::kernel_pos_t       kernel_colD_pos_i,
    input  conv_pkg::pixel_t [4:0]      kernel_colD_data_i,
    input  logic                        m_tready_i,
    output logic                        m_tvalid_o,
    output conv_pkg::pixel_t [4:0][4:0] m_tdata_o,
    output logic                        m_tuser_o,
    output logic                        m_tlast_o
);
    import conv_pkg::*;

    typedef struct packed {
        pixel_t [4:0] data;
        kernel_pos_t  pos;
        logic         cvld;
    } col_t;

    col_t [4:0] col_q, col_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic       take, flush, shift;

    logic              m_tvalid_q;
    pixel_t [4:0][4:0] m_tdata_q;
    logic              m_tuser_q, m_tlast_q;

    // ------------------------------------------------------------------
    // Column shift register and end-of-frame flush counter
    // ------------------------------------------------------------------
    always_comb begin
        take        = kernel_colD_vld_i & m_tready_i;
        flush       = ~kernel_colD_vld_i & m_tready_i & (flush_cnt_q != 2'd0);
        shift       = take | flush;
        col_d       = col_q;
        flush_cnt_d = flush_cnt_q;

        if (shift) begin
            for (int k = 0; k < 4; k++) col_d[k] = col_q[k+1];
            col_d[4] = '0;
            if (take) begin
                col_d[4].data = kernel_colD_data_i;
                col_d[4].pos  = kernel_colD_pos_i;
                col_d[4].cvld = 1'b1;
            end
        end

        // A fresh column always wins over a pending flush: the next frame
        // pushes the old frame's tail out itself.
        if (take)
            flush_cnt_d = (kernel_colD_pos_i.e2 & kernel_colD_pos_i.s2) ? 2'd2 : 2'd0;
        else if (flush)
            flush_cnt_d = flush_cnt_q - 2'd1;
    end

    // ------------------------------------------------------------------
    // Window formation from the post-shift columns.  Horizontal padding
    // first, then each column is padded vertically, so corners resolve to
    // the centre-adjacent corner value in replicate mode.  Flushed columns
    // need no special case: they only ever sit east of a pixel flagged e1/e2.
    // ------------------------------------------------------------------
    kernel_pos_t       cpos;
    pixel_t [4:0][4:0] hsel;
    pixel_t [4:0][4:0] win;

    assign cpos = col_d[2].pos;

    generate
        if (PAD_MODE == 0) begin : g_hzero
            always_comb begin
                for (int c = 0; c < 5; c++) hsel[c] = col_d[c].data;
                if (cpos.w2 | cpos.w1) hsel[0] = '0;
                if (cpos.w2)           hsel[1] = '0;
                if (cpos.e2)           hsel[3] = '0;
                if (cpos.e2 | cpos.e1) hsel[4] = '0;
            end
        end else begin : g_hrep
            always_comb begin
                for (int c = 0; c < 5; c++) hsel[c] = col_d[c].data;
                if (cpos.w2) begin
                    hsel[0] = col_d[2].data;
                    hsel[1] = col_d[2].data;
                end else if (cpos.w1) begin
                    hsel[0] = col_d[1].data;
                end
                if (cpos.e2) begin
                    hsel[3] = col_d[2].data;
                    hsel[4] = col_d[2].data;
                end else if (cpos.e1) begin
                    hsel[4] = col_d[3].data;
                end
            end
        end

        for (genvar c = 0; c < 5; c++) begin : g_col
            conv_kernel_win_rowpad #(.PAD_MODE(PAD_MODE)) u_rowpad (
                .col_i (hsel[c]),
                .n2_i  (cpos.n2),
                .n1_i  (cpos.n1),
                .s1_i  (cpos.s1),
                .s2_i  (cpos.s2),
                .col_o (win[c])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered output.  With ready low nothing moves; with
    // ready high the presented window is consumed, so valid only survives
    // if a shift produced a new one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            col_q       <= '0;
            flush_cnt_q <= 2'd0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tuser_q   <= 1'b0;
            m_tlast_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            flush_cnt_q <= flush_cnt_d;
            if (m_tready_i) begin
                m_tvalid_q <= shift & col_d[2].cvld;
                if (shift) begin
                    m_tdata_q <= win;
                    m_tuser_q <= cpos.w2 & cpos.n2;
                    m_tlast_q <= cpos.e2;
                end
            end
        end
    end

    assign m_tvalid_o = m_tvalid_q;
    assign m_tdata_o  = m_tdata_q;
    assign m_tuser_o  = m_tuser_q;
    assign m_tlast_o  = m_tlast_q;
endmodule

// File: tb/tb_conv_kernel_win.sv
module tb_conv_kernel_win;
    import conv_pkg::*;

    typedef struct {
        pixel_t [4:0][4:0] data;
        logic              user;
        logic              last;
        int                x;
        int                y;
    } exp_t;

    logic                  clk;
    logic                  arst_n;
    logic                  vld;
    kernel_pos_t           pos;
    pixel_t [4:0]          cdata;
    logic                  rdy;

    logic                  tvalid0, tuser0, tlast0;
    pixel_t [4:0][4:0]     tdata0;
    logic                  tvalid1, tuser1, tlast1;
    pixel_t [4:0][4:0]     tdata1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    conv_kernel_win #(.PAD_MODE(0)) u_dut0 (
        .clk(clk), .arst_n(arst_n),
        .kernel_colD_vld_i(vld), .kernel_colD_pos_i(pos), .kernel_colD_data_i(cdata),
        .m_tready_i(rdy), .m_tvalid_o(tvalid0), .m_tdata_o(tdata0),
        .m_tuser_o(tuser0), .m_tlast_o(tlast0)
    );

    conv_kernel_win #(.PAD_MODE(1)) u_dut1 (
        .clk(clk), .arst_n(arst_n),
        .kernel_colD_vld_i(vld), .kernel_colD_pos_i(pos), .kernel_colD_data_i(cdata),
        .m_tready_i(rdy), .m_tvalid_o(tvalid1), .m_tdata_o(tdata1),
        .m_tuser_o(tuser1), .m_tlast_o(tlast1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (5x5 frame, pixel = 16*row+col) ----
    function automatic kernel_pos_t mk_pos(int x, int y);
        kernel_pos_t p;
        p    = '0;
        p.w2 = (x == 0);
        p.w1 = (x == 1);
        p.e1 = (x == 3);
        p.e2 = (x == 4);
        p.n2 = (y == 0);
        p.n1 = (y == 1);
        p.s1 = (y == 3);
        p.s2 = (y == 4);
        return p;
    endfunction

    // Out-of-frame rows carry junk so that masking is actually exercised.
    function automatic pixel_t [4:0] mk_col(int x, int y);
        pixel_t [4:0] c;
        for (int k = 0; k < 5; k++) begin
            int r;
            r = y + 2 - k;
            if (r >= 0 && r <= 4) c[k] = 8'(16 * r + x);
            else                  c[k] = 8'(8'hE0 + k);
        end
        return c;
    endfunction

    function automatic exp_t mk_exp(int x, int y, bit pad);
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 5; r++) begin
                int xx, yy;
                bit oob;
                xx  = x + c - 2;
                yy  = y + 2 - r;
                oob = (xx < 0) || (xx > 4) || (yy < 0) || (yy > 4);
                if (pad) begin
                    if (xx < 0) xx = 0;
                    if (xx > 4) xx = 4;
                    if (yy < 0) yy = 0;
                    if (yy > 4) yy = 4;
                    e.data[c][r] = 8'(16 * yy + xx);
                end else begin
                    e.data[c][r] = oob ? 8'h00 : 8'(16 * yy + xx);
                end
            end
        end
        e.user = (x == 0) && (y == 0);
        e.last = (x == 4);
        e.x    = x;
        e.y    = y;
        return e;
    endfunction

    // ---------------- checking helpers --------------------------------------
    task automatic chk(string name, logic [255:0] act, logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitor: pop on every handshake -----------------------
    always @(negedge clk) begin
        if (rdy && tvalid0) begin
            n_chk++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL pad0_unexpected_window: got %0h expected none", tdata0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (tdata0 !== e.data || tuser0 !== e.user || tlast0 !== e.last) begin
                    n_fail++;
                    $display("FAIL pad0_window(%0d,%0d): got %0h u%0b l%0b expected %0h u%0b l%0b",
                             e.x, e.y, tdata0, tuser0, tlast0, e.data, e.user, e.last);
                end
            end
        end
        if (rdy && tvalid1) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL pad1_unexpected_window: got %0h expected none", tdata1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (tdata1 !== e.data || tuser1 !== e.user || tlast1 !== e.last) begin
                    n_fail++;
                    $display("FAIL pad1_window(%0d,%0d): got %0h u%0b l%0b expected %0h u%0b l%0b",
                             e.x, e.y, tdata1, tuser1, tlast1, e.data, e.user, e.last);
                end
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    // All drivers start and end at posedge + 1.
    task automatic send(int x, int y);
        vld   = 1'b1;
        rdy   = 1'b1;
        pos   = mk_pos(x, y);
        cdata = mk_col(x, y);
        q0.push_back(mk_exp(x, y, 1'b0));
        q1.push_back(mk_exp(x, y, 1'b1));
        @(posedge clk); #1;
        vld   = 1'b0;
        pos   = '0;
        cdata = '0;
    endtask

    task automatic idle(int n);
        vld = 1'b0;
        rdy = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic stall(int n);
        logic              v0, v1;
        pixel_t [4:0][4:0] d0, d1;
        vld = 1'b0;
        rdy = 1'b0;
        v0 = tvalid0; d0 = tdata0;
        v1 = tvalid1; d1 = tdata1;
        chk("stall_entry_valid", 256'(v0), 256'(1));
        repeat (n) begin
            @(negedge clk);
            chk("stall_valid0", 256'(tvalid0), 256'(v0));
            chk("stall_data0",  256'(tdata0),  256'(d0));
            chk("stall_valid1", 256'(tvalid1), 256'(v1));
            chk("stall_data1",  256'(tdata1),  256'(d1));
            @(posedge clk); #1;
        end
        rdy = 1'b1;
    endtask

    // Final two windows must drain on exactly the two flush cycles.
    task automatic drain_check(string name);
        idle(2);
        @(negedge clk); #1;
        chk({name, "_drained0"}, 256'(q0.size()), 256'(0));
        chk({name, "_drained1"}, 256'(q1.size()), 256'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_quiet0"}, 256'(tvalid0), 256'(0));
        chk({name, "_quiet1"}, 256'(tvalid1), 256'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        arst_n = 1'b0;
        vld    = 1'b0;
        rdy    = 1'b0;
        pos    = '0;
        cdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid0", 256'(tvalid0), 256'(0));
        chk("rst_user0",  256'(tuser0),  256'(0));
        chk("rst_last0",  256'(tlast0),  256'(0));
        chk("rst_data0",  256'(tdata0),  256'(0));
        chk("rst_valid1", 256'(tvalid1), 256'(0));
        chk("rst_data1",  256'(tdata1),  256'(0));
        @(posedge clk); #1;
        arst_n = 1'b1;
        rdy    = 1'b1;
        idle(2);

        // Frame A: continuous, with a 3-cycle stall mid-line after (2,1).
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) begin
                send(x, y);
                if (x == 2 && y == 1) stall(3);
            end
        drain_check("frameA");

        // Frame B, then frame C's first column lands on flush cycle 1.
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                send(x, y);
        send(0, 0);
        send(1, 0);
        idle(3);   // no stale flush may shift here
        for (int i = 2; i < 25; i++) send(i % 5, i / 5);
        drain_check("frameC");

        // Frame D, reset after pixel (2,1).
        for (int i = 0; i < 8; i++) send(i % 5, i / 5);
        arst_n = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("midrst_valid0", 256'(tvalid0), 256'(0));
        chk("midrst_valid1", 256'(tvalid1), 256'(0));
        @(posedge clk); #1;
        arst_n = 1'b1;
        idle(3);
        @(negedge clk);
        chk("postrst_idle_valid0", 256'(tvalid0), 256'(0));
        @(posedge clk); #1;

        // Frame E: first window only after the third column.
        for (int i = 0; i < 25; i++) begin
            send(i % 5, i / 5);
            if (i < 3) begin
                @(negedge clk);
                chk($sformatf("postrst_col%0d_valid0", i), 256'(tvalid0), 256'(i == 2));
                chk($sformatf("postrst_col%0d_valid1", i), 256'(tvalid1), 256'(i == 2));
                @(posedge clk); #1;
                // the stray idle cycle above consumed any window; re-queue nothing
                // since the monitor already popped it on that negedge
            end
        end
        drain_check("frameE");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
